ps2_keyscan_rx: RTL
===================

PS2_KEYSCAN_RX -- requirements
Module: ps2_keyscan_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8: consecutive equal ps2_clk samples needed to change the filtered clock level (range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: scan-code FIFO entries (power of 2, range 2..64).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000: clk cycles without a filtered falling edge before an in-progress frame is aborted.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port ps2_clk, input, 1: asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2_data, input, 1: asynchronous PS/2 data line.
REQ-008 SHALL have port rd_en, input, 1: pop the FIFO head when valid=1.
REQ-009 SHALL have port data_out, output, 10: FIFO head {ext, brk, code[7:0]}.
REQ-010 SHALL have port valid, output, 1: FIFO not empty.
REQ-011 SHALL have port full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port overflow, output, 1: sticky flag, a code was dropped because the FIFO was full.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on each discarded frame.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers before any use.
REQ-015 SHALL change the filtered clock level only after FILT_LEN consecutive synchronised samples differ from it; a filtered 1->0 transition is an "edge".
REQ-016 SHALL run a receive FSM with states IDLE, DATA, PARITY, STOP, sampling synchronised ps2_data once per edge.
REQ-017 IDLE: edge with data=0 -> DATA with bit count cleared; edge with data=1 -> stay IDLE and pulse frame_err.
REQ-018 DATA: shift in 8 bits LSB first, then -> PARITY; PARITY: capture bit, then -> STOP.
REQ-019 STOP: edge with data=1 and a frame valid per REQ-026 accepts the byte; otherwise pulse frame_err; either way -> IDLE.
REQ-020 SHALL, in any state other than IDLE, abort to IDLE and pulse frame_err when TIMEOUT_CYC cycles pass with no edge; the timeout counter SHALL reset on every edge.
REQ-021 Accepted 0xE0 SHALL set ext; accepted 0xF0 SHALL set brk; neither SHALL be pushed.
REQ-022 Any other accepted byte SHALL push {ext, brk, byte} and clear ext and brk in the same cycle.
REQ-023 A frame_err SHALL clear ext and brk.
REQ-024 The push SHALL occur on the cycle after the STOP edge; valid/data_out SHALL reflect a push into an empty FIFO one cycle later (first-word fall-through).
REQ-025 FIFO boundaries:
- rd_en with valid=0 is ignored.
- A push while full and no pop drops the code and sets overflow.
- Push and pop in the same cycle while full both succeed, with no overflow.
- Pointers wrap modulo FIFO_DEPTH.

Configuration
REQ-026 With PS2_PARITY_CHECK_EN defined, a frame SHALL be valid only if the 8 data bits plus the parity bit have odd weight; a mismatch pulses frame_err and the byte is discarded. Without it, the parity bit SHALL be captured and ignored.

Reset
REQ-027 rst=1 at a clk edge SHALL, regardless of any frame in progress:
- set the FSM to IDLE;
- clear the counters, ext, brk and FIFO pointers;
- force the filtered clock to 1;
- drive data_out=0, valid=0, full=0, overflow=0, frame_err=0.
REQ-028 After reset, a partially received frame SHALL NOT produce a push.

Verification
REQ-029 Frame 0x1C, correct parity -> valid=1 two cycles after the STOP edge, data_out=0x01C.
REQ-030 Frames E0, F0, 75 -> exactly one entry, data_out=0x375, and ext/brk are clear afterwards.
REQ-031 Push FIFO_DEPTH+1 codes with rd_en=0 -> full=1, overflow=1, the first FIFO_DEPTH codes are read back in order, the extra code is absent.
REQ-032 Frame 0x1C with bad parity -> macro defined: frame_err pulse and no push; undefined: data_out=0x01C.
REQ-033 Stop after 4 data bits, hold ps2_clk high -> frame_err pulse after TIMEOUT_CYC cycles; the next full frame 0x29 gives data_out=0x029.
REQ-034 Glitches on ps2_clk shorter than FILT_LEN cycles, plus rst asserted mid-frame -> no edges counted, no push, all outputs 0.

Source files
------------

// File: rtl/ps2_keyscan_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, frame FSM, E0/F0 prefix folding, FWFT scan-code FIFO.
// Optional odd-parity check when PS2_PARITY_CHECK_EN is defined; otherwise the parity bit is consumed unchecked.
module ps2_keyscan_rx #(
  parameter int FILT_LEN    = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [9:0] data_out,
  output logic       valid,
  output logic       full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int FW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      if (clk_s2 != filt) begin
        if (fcnt == FW'(FILT_LEN - 1)) begin
          filt <= clk_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // The edge is the cycle in which the filtered level is about to drop.
  assign fall = filt && !clk_s2 && (fcnt == FW'(FILT_LEN - 1));

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;
  logic          ext, brk;
  logic          push_vld;
  logic [9:0]    push_dat;
  logic          err_c, acc_c, par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    err_c   = 1'b0;
    acc_c   = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE:   if (!dat_s2) state_d = DATA; else err_c = 1'b1;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (dat_s2 && par_ok) acc_c = 1'b1;
          else                  err_c = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_c   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      frame_err <= err_c;
      push_vld  <= 1'b0;
      tcnt      <= (fall || state_q == IDLE) ? '0 : tcnt + TW'(1);
      if (fall) begin
        case (state_q)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef PS2_PARITY_CHECK_EN
          PARITY: par_bit <= dat_s2;
`endif
          default: ;
        endcase
      end
      // Prefix bytes only arm flags; everything else carries them into the FIFO.
      if (err_c) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (acc_c) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          push_vld <= 1'b1;
          push_dat <= {ext, brk, shreg};
          ext      <= 1'b0;
          brk      <= 1'b0;
        end
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, wr;

  assign valid    = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = rd_en && valid;
  assign wr       = push_vld && (!full || pop);
  assign data_out = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_vld && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
